// File: rtl/mem_bus_ctrl_pkg.sv
// Shared types and constants for the memory/IO bus controller.
package mem_bus_ctrl_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_STALL, ST_RESP} bus_state_t;

  localparam logic [11:0] IO_IN_ADDR_DEF  = 12'hFFE;
  localparam logic [11:0] IO_OUT_ADDR_DEF = 12'hFFF;
  localparam logic        RW_READ         = 1'b0;
  localparam logic        RW_WRITE        = 1'b1;
endpackage

// File: rtl/mem_bus_ctrl_if.sv
// Processor-side access bus: request/rw/addr/wdata in, rdata/ack/busy back.
interface mem_bus_ctrl_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
) ();
  logic              req;
  logic              rw;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;
  logic              busy;

  modport master (output req, rw, addr, wdata, input rdata, ack, busy);
  modport slave  (input req, rw, addr, wdata, output rdata, ack, busy);
endinterface

// File: rtl/mem_bus_ctrl_out_fifo.sv
// Output-port FIFO; a push into a full FIFO is taken only when a pop frees the slot on the same edge.
module mem_bus_ctrl_out_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end
endmodule

// File: rtl/mem_bus_ctrl.sv
// Memory/IO bus controller: RAM accesses with wait states, one input port, one FIFO-backed output port.
//   state  | meaning
//   IDLE   | waiting for req
//   ACCESS | RAM access in flight, wait counter running down
//   STALL  | output-port write waiting for FIFO space
//   RESP   | ack cycle, rdata valid
module mem_bus_ctrl
  import mem_bus_ctrl_pkg::*;
#(
  parameter int                ADDR_W      = 12,
  parameter int                DATA_W      = 16,
  parameter int                WAIT_STATES = 1,
  parameter logic [ADDR_W-1:0] IO_IN_ADDR  = ADDR_W'(IO_IN_ADDR_DEF),
  parameter logic [ADDR_W-1:0] IO_OUT_ADDR = ADDR_W'(IO_OUT_ADDR_DEF),
  parameter int                FIFO_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_bus_ctrl_if.slave     bus,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_q,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);
  localparam int CW    = 3;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  bus_state_t        state, state_nxt;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] lat_wdata;
  logic [DATA_W-1:0] rdata_q;
  logic              ram_rd;
  logic              in_hit, out_hit, is_ram;
  logic              fifo_push, fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_din;
  logic [CNT_W-1:0]  fifo_count;

  assign in_hit  = (bus.addr == IO_IN_ADDR);
  assign out_hit = (bus.addr == IO_OUT_ADDR);
  assign is_ram  = !in_hit && !out_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    fifo_push = 1'b0;
    fifo_din  = bus.wdata;
    unique case (state)
      ST_IDLE: begin
        if (bus.req) begin
          if (is_ram) begin
            state_nxt = ST_ACCESS;
          end else if (out_hit && bus.rw == RW_WRITE && fifo_full) begin
            state_nxt = ST_STALL;
          end else begin
            state_nxt = ST_RESP;
            fifo_push = out_hit && bus.rw == RW_WRITE;
          end
        end
      end
      ST_ACCESS: if (cnt == '0) state_nxt = ST_RESP;
      ST_STALL: begin
        fifo_push = 1'b1;
        fifo_din  = lat_wdata;
        if (!fifo_full || out_ready) state_nxt = ST_RESP;
      end
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      lat_wdata <= '0;
      rdata_q   <= '0;
      ram_rd    <= 1'b0;
      ram_addr  <= '0;
      ram_we    <= 1'b0;
      ram_wdata <= '0;
    end else begin
      ram_we <= 1'b0;
      if (state == ST_IDLE && bus.req) begin
        lat_wdata <= bus.wdata;
        ram_rd    <= is_ram && bus.rw == RW_READ;
        if (is_ram) begin
          ram_addr <= bus.addr;
          ram_we   <= bus.rw;
          cnt      <= CW'(WAIT_STATES);
          if (bus.rw == RW_WRITE) ram_wdata <= bus.wdata;
        end else if (bus.rw == RW_READ) begin
          rdata_q <= in_hit ? in_data : DATA_W'(fifo_count);
        end
      end
      if (state == ST_ACCESS && cnt != '0) cnt <= cnt - 1'b1;
      if (state == ST_RESP && ram_rd) rdata_q <= ram_q;
    end
  end

  // With zero wait states the synchronous RAM only presents data in the ack cycle,
  // so RAM reads are forwarded from ram_q during RESP and held from the register after.
  assign bus.rdata = (state == ST_RESP && ram_rd) ? ram_q : rdata_q;
  assign bus.ack   = (state == ST_RESP);
  assign bus.busy  = (state != ST_IDLE);
  assign out_valid = ~fifo_empty;

  mem_bus_ctrl_out_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_out_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (out_ready),
    .din   (fifo_din),
    .head  (out_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );
endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Scoreboard bench for mem_bus_ctrl: main instance (1 wait state) plus 0/3 wait-state latency instances.
`timescale 1ns/1ps
module tb_mem_bus_ctrl;
  import mem_bus_ctrl_pkg::*;
  localparam int AW = 12;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int pops = 0;

  mem_bus_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bm ();
  mem_bus_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) b0 ();
  mem_bus_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) b3 ();

  logic [AW-1:0] m_ram_addr, r0_addr, r3_addr;
  logic          m_ram_we, r0_we, r3_we;
  logic [DW-1:0] m_ram_wdata, r0_wdata, r3_wdata;
  logic [DW-1:0] m_ram_q, r0_q, r3_q;
  logic [DW-1:0] in_data;
  logic [DW-1:0] m_out_data, o0_data, o3_data;
  logic          m_out_valid, o0_valid, o3_valid;
  logic          m_out_ready;
  logic          no_ready = 1'b0;

  mem_bus_ctrl #(.WAIT_STATES(1)) u_main (
    .clk(clk), .rst_n(rst_n), .bus(bm),
    .ram_addr(m_ram_addr), .ram_we(m_ram_we), .ram_wdata(m_ram_wdata), .ram_q(m_ram_q),
    .in_data(in_data), .out_data(m_out_data), .out_valid(m_out_valid), .out_ready(m_out_ready));

  mem_bus_ctrl #(.WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst_n(rst_n), .bus(b0),
    .ram_addr(r0_addr), .ram_we(r0_we), .ram_wdata(r0_wdata), .ram_q(r0_q),
    .in_data(in_data), .out_data(o0_data), .out_valid(o0_valid), .out_ready(no_ready));

  mem_bus_ctrl #(.WAIT_STATES(3)) u_ws3 (
    .clk(clk), .rst_n(rst_n), .bus(b3),
    .ram_addr(r3_addr), .ram_we(r3_we), .ram_wdata(r3_wdata), .ram_q(r3_q),
    .in_data(in_data), .out_data(o3_data), .out_valid(o3_valid), .out_ready(no_ready));

  // Preloaded RAM contents
  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    if (a == 12'h010) return 16'h1234;
    return {4'h0, a} ^ 16'hA5A5;
  endfunction

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return {4'hC, a};
  endfunction

  logic [DW-1:0] mem [4096];
  bit            written [4096];
  always @(posedge clk) begin
    if (m_ram_we) begin
      mem[m_ram_addr]     <= m_ram_wdata;
      written[m_ram_addr] <= 1'b1;
    end
    m_ram_q <= written[m_ram_addr] ? mem[m_ram_addr] : init_val(m_ram_addr);
    r0_q    <= pat(r0_addr);
    r3_q    <= pat(r3_addr);
  end

  // Reference model state
  logic [DW-1:0] ref_mem [int];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] out_q [$];
  logic [DW-1:0] last_rd = '0;

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return init_val(a);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every ack against the scoreboard and every pop against the output queue
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (bm.ack) begin
        if (exp_q.size() == 0) check("ack_unexpected", exp_q.size(), 1);
        else check("ack_rdata", bm.rdata, exp_q.pop_front());
      end
      if (m_out_valid && m_out_ready) begin
        pops++;
        if (out_q.size() == 0) check("pop_unexpected", out_q.size(), 1);
        else check("out_data", m_out_data, out_q.pop_front());
      end
    end
  end

  task automatic do_access(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input int lat);
    int ack_c, we_n;
    bit busy_ok, wd_ok, is_ram;
    logic [AW-1:0] a1;
    is_ram = (a != 12'hFFE) && (a != 12'hFFF);
    if (rw == RW_READ) begin
      if (is_ram)            last_rd = ref_rd(a);
      else if (a == 12'hFFE) last_rd = in_data;
      else                   last_rd = 16'(out_q.size());
    end else if (is_ram) begin
      ref_mem[int'(a)] = d;
    end else if (a == 12'hFFF) begin
      out_q.push_back(d);
    end
    exp_q.push_back(last_rd);
    @(posedge clk); #1;
    bm.req = 1'b1; bm.rw = rw; bm.addr = a; bm.wdata = d;
    ack_c = 0; we_n = 0; busy_ok = 1'b1; wd_ok = 1'b1; a1 = '0;
    for (int c = 1; c <= 40 && ack_c == 0; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        bm.req = 1'b0; bm.addr = 12'($urandom); bm.wdata = 16'($urandom);
      end
      @(negedge clk);
      if (!bm.busy) busy_ok = 1'b0;
      if (c == 1) a1 = m_ram_addr;
      if (m_ram_we) begin
        we_n++;
        if (m_ram_addr !== a || m_ram_wdata !== d) wd_ok = 1'b0;
      end
      if (bm.ack) ack_c = c;
    end
    check("ack_cycle", ack_c, lat);
    check("busy_held", busy_ok, 1);
    check("we_pulses", we_n, (is_ram && rw == RW_WRITE) ? 1 : 0);
    check("we_addr_data", wd_ok, 1);
    if (is_ram) check("ram_addr_c1", a1, a);
  endtask

  task automatic sweep(input logic [AW-1:0] a);
    int c0, c3;
    logic [DW-1:0] e;
    e  = (a == 12'hFFE) ? in_data : pat(a);
    c0 = 0; c3 = 0;
    @(posedge clk); #1;
    b0.req = 1'b1; b0.rw = RW_READ; b0.addr = a;
    b3.req = 1'b1; b3.rw = RW_READ; b3.addr = a;
    for (int c = 1; c <= 20 && (c0 == 0 || c3 == 0); c++) begin
      @(posedge clk); #1;
      if (c == 1) begin b0.req = 1'b0; b3.req = 1'b0; end
      @(negedge clk);
      if (b0.ack && c0 == 0) begin c0 = c; check("ws0_rdata", b0.rdata, e); end
      if (b3.ack && c3 == 0) begin c3 = c; check("ws3_rdata", b3.rdata, e); end
    end
    check("ws0_ack_cycle", c0, (a == 12'hFFE) ? 1 : 2);
    check("ws3_ack_cycle", c3, (a == 12'hFFE) ? 1 : 5);
  endtask

  task automatic drain(input int n);
    @(posedge clk); #1 m_out_ready = 1'b1;
    repeat (n) @(posedge clk);
    #1 m_out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, p0;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    bm.req = 1'b0; bm.rw = 1'b0; bm.addr = '0; bm.wdata = '0;
    b0.req = 1'b0; b0.rw = 1'b0; b0.addr = '0; b0.wdata = '0;
    b3.req = 1'b0; b3.rw = 1'b0; b3.addr = '0; b3.wdata = '0;
    in_data = 16'h00A5; m_out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ack", bm.ack, 0);
    check("rst_busy", bm.busy, 0);
    check("rst_rdata", bm.rdata, 0);
    check("rst_ram_addr", m_ram_addr, 0);
    check("rst_ram_we", m_ram_we, 0);
    check("rst_ram_wdata", m_ram_wdata, 0);
    check("rst_out_valid", m_out_valid, 0);
    check("rst_out_data", m_out_data, 0);
    check("rst_ws0_idle", {b0.busy, r0_we, o0_valid, r0_wdata, o0_data}, 0);
    check("rst_ws3_idle", {b3.busy, r3_we, o3_valid, r3_wdata, o3_data}, 0);
    rst_n = 1'b1;

    do_access(RW_READ, 12'h010, 16'h0, 3);
    @(negedge clk);
    check("busy_drop", bm.busy, 0);
    do_access(RW_WRITE, 12'h020, 16'hBEEF, 3);
    do_access(RW_READ, 12'h020, 16'h0, 3);

    sweep(12'h010);
    sweep(12'h123);
    sweep(12'hFFE);
    do_access(RW_READ, 12'hFFE, 16'h0, 1);

    for (int i = 1; i <= 4; i++) do_access(RW_WRITE, 12'hFFF, 16'(i), 1);
    p0 = pops;
    fork
      do_access(RW_WRITE, 12'hFFF, 16'h0005, 4);
      begin repeat (4) @(posedge clk); #2 m_out_ready = 1'b1; end
    join
    repeat (6) @(negedge clk);
    check("stall_drain_pops", pops - p0, 5);
    check("stall_drain_empty", m_out_valid, 0);
    #1 m_out_ready = 1'b0;

    do_access(RW_WRITE, 12'hFFF, 16'h00A1, 1);
    do_access(RW_WRITE, 12'hFFF, 16'h00A2, 1);
    do_access(RW_READ, 12'hFFF, 16'h0, 1);
    drain(4);

    for (int i = 0; i < 80; i++) begin
      k = $urandom_range(0, 9);
      a = 12'($urandom_range(0, 63));
      d = 16'($urandom);
      in_data = 16'($urandom);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
      if (k <= 3)      do_access(RW_READ, a, d, 3);
      else if (k <= 5) do_access(RW_WRITE, a, d, 3);
      else if (k == 6) do_access(1'($urandom_range(0, 1)), 12'hFFE, d, 1);
      else if (k == 7 && out_q.size() < 4) do_access(RW_WRITE, 12'hFFF, d, 1);
      else if (k == 8) do_access(RW_READ, 12'hFFF, d, 1);
      else drain($urandom_range(1, 5));
    end
    drain(5);
    check("drained", out_q.size(), 0);

    // Reset in the middle of a RAM write with the output FIFO non-empty
    do_access(RW_WRITE, 12'hFFF, 16'h0077, 1);
    @(posedge clk); #1;
    bm.req = 1'b1; bm.rw = RW_WRITE; bm.addr = 12'h030; bm.wdata = 16'hDEAD;
    @(posedge clk); #1 bm.req = 1'b0;
    @(negedge clk);
    check("abort_we_before", m_ram_we, 1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_ack", bm.ack, 0);
    check("abort_busy", bm.busy, 0);
    check("abort_out_valid", m_out_valid, 0);
    check("abort_ram_we", m_ram_we, 0);
    exp_q.delete();
    out_q.delete();
    last_rd = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_access(RW_READ, 12'h030, 16'h0, 3);
    do_access(RW_READ, 12'h010, 16'h0, 3);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
